// File: rtl/ovr_i_guard.sv
// ============================================================================
// Module      : ovr_i_guard
// Description : Over-current guard for the motor drive. Synchronizes the
//               OVR_I_lft/OVR_I_rght flags. Ignores them during the blanking
//               window at each PWM period start. Trips a latched shutdown
//               after FAULT_CNT consecutive over-current periods. Returns to
//               RUN only after clr_fault and RECOV_CNT clean periods.
//               Optional feature macro: OVR_I_DIAG_EN (sticky per-side
//               fault diagnostics; tied low when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ovr_i_guard #(
   parameter int BLANK_CYC = 40,
   parameter int FAULT_CNT = 7,
   parameter int RECOV_CNT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       OVR_I_lft,
   input  logic       OVR_I_rght,
   input  logic       PWM_synch,
   input  logic       clr_fault,
   output logic       OVR_I_shtdwn,
   output logic [3:0] ovr_cnt,
   output logic       fault_lft,
   output logic       fault_rght
);

   // Blank counter is at least 6 bits wide, wider only if BLANK_CYC needs it
   localparam int BW = ($clog2(BLANK_CYC + 1) > 6) ? $clog2(BLANK_CYC + 1) : 6;
   localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYC);
   localparam logic [3:0]    FAULT_MAX = 4'(FAULT_CNT);
   localparam logic [3:0]    RECOV_MAX = 4'(RECOV_CNT);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FAULT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      sync_l, sync_r;
   logic            ovr_l_s, ovr_r_s;
   logic [BW-1:0]   blank_cnt;
   logic            window_open;
   logic            per_l, per_r;
   logic [3:0]      rec_cnt, rec_nxt;
   logic [3:0]      cnt_nxt, cnt_inc;
   logic            diag_set, diag_clr;

   // Two-flop synchronizers for the asynchronous over-current flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_l <= 2'b00;
         sync_r <= 2'b00;
      end else begin
         sync_l <= {sync_l[0], OVR_I_lft};
         sync_r <= {sync_r[0], OVR_I_rght};
      end
   end

   assign ovr_l_s = sync_l[1];
   assign ovr_r_s = sync_r[1];

   // Blanking counter: restarts on each PWM period, saturates at BLANK_CYC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_cnt <= '0;
      end else if (PWM_synch) begin
         blank_cnt <= '0;
      end else if (blank_cnt != BLANK_MAX) begin
         blank_cnt <= blank_cnt + 1'b1;
      end
   end

   // A pulse coinciding with PWM_synch is never qualified
   assign window_open = (blank_cnt == BLANK_MAX) && !PWM_synch;

   // Per-period over-current flags, consumed and cleared at period start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_l <= 1'b0;
         per_r <= 1'b0;
      end else if (PWM_synch) begin
         per_l <= 1'b0;
         per_r <= 1'b0;
      end else begin
         if (window_open && ovr_l_s) per_l <= 1'b1;
         if (window_open && ovr_r_s) per_r <= 1'b1;
      end
   end

   // FSM state, period counter, recovery counter and shutdown register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         ovr_cnt      <= 4'd0;
         rec_cnt      <= 4'd0;
         OVR_I_shtdwn <= 1'b0;
      end else begin
         state        <= state_nxt;
         ovr_cnt      <= cnt_nxt;
         rec_cnt      <= rec_nxt;
         OVR_I_shtdwn <= (state_nxt != RUN);
      end
   end

   assign cnt_inc = (ovr_cnt == 4'hF) ? ovr_cnt : ovr_cnt + 4'd1;

   // Next-state logic and counter updates
   always_comb begin
      state_nxt = state;
      cnt_nxt   = ovr_cnt;
      rec_nxt   = rec_cnt;
      diag_set  = 1'b0;
      diag_clr  = 1'b0;
      case (state)
         RUN: begin
            if (PWM_synch) begin
               if (per_l || per_r) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == FAULT_MAX) begin
                     state_nxt = FAULT;
                     diag_set  = 1'b1;
                  end
               end else begin
                  cnt_nxt = 4'd0;
               end
            end
         end
         FAULT: begin
            if (clr_fault) begin
               state_nxt = RECOVER;
               cnt_nxt   = 4'd0;
               rec_nxt   = 4'd0;
            end
         end
         RECOVER: begin
            // No blanking here: any synchronized over-current re-faults
            if (ovr_l_s || ovr_r_s) begin
               state_nxt = FAULT;
            end else if (PWM_synch) begin
               rec_nxt = rec_cnt + 4'd1;
               if (rec_nxt == RECOV_MAX) begin
                  state_nxt = RUN;
                  diag_clr  = 1'b1;
               end
            end
         end
         default: state_nxt = RUN;
      endcase
   end

`ifdef OVR_I_DIAG_EN
   // Sticky per-side trip diagnostics, cleared on successful recovery
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_lft  <= 1'b0;
         fault_rght <= 1'b0;
      end else if (diag_set) begin
         fault_lft  <= fault_lft  | per_l;
         fault_rght <= fault_rght | per_r;
      end else if (diag_clr) begin
         fault_lft  <= 1'b0;
         fault_rght <= 1'b0;
      end
   end
`else
   assign fault_lft  = 1'b0;
   assign fault_rght = 1'b0;

   // Diagnostic strobes have no consumer without the feature
   logic unused_diag;
   assign unused_diag = diag_set ^ diag_clr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ovr_i_guard.sv
// ============================================================================
// Module      : tb_ovr_i_guard
// Description : Self-checking bench for ovr_i_guard: directed period table,
//               hand-written corner sequences and randomized periods, all
//               compared every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ovr_i_guard;

   localparam int BLANK_CYC = 40;
   localparam int FAULT_CNT = 7;
   localparam int RECOV_CNT = 4;
`ifdef OVR_I_DIAG_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       OVR_I_lft, OVR_I_rght, PWM_synch, clr_fault;
   logic       OVR_I_shtdwn;
   logic [3:0] ovr_cnt;
   logic       fault_lft, fault_rght;

   int n_checks = 0;
   int n_errors = 0;

   ovr_i_guard #(
      .BLANK_CYC (BLANK_CYC),
      .FAULT_CNT (FAULT_CNT),
      .RECOV_CNT (RECOV_CNT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .OVR_I_lft    (OVR_I_lft),
      .OVR_I_rght   (OVR_I_rght),
      .PWM_synch    (PWM_synch),
      .clr_fault    (clr_fault),
      .OVR_I_shtdwn (OVR_I_shtdwn),
      .ovr_cnt      (ovr_cnt),
      .fault_lft    (fault_lft),
      .fault_rght   (fault_rght)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0=RUN 1=FAULT 2=RECOVER
   int m_mode, m_cnt, m_rec, m_since;
   bit m_pl, m_pr, m_fl, m_fr;
   bit m_l[2];
   bit m_r[2];
   bit watch, sh_low;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_rec = 0; m_since = 0;
      m_pl = 0; m_pr = 0; m_fl = 0; m_fr = 0;
      m_l[0] = 0; m_l[1] = 0; m_r[0] = 0; m_r[1] = 0;
   endtask

   // Advance the model by one clock using the inputs about to be sampled
   task automatic model_edge();
      bit sl, sr, win, anyp;
      sl   = m_l[1];
      sr   = m_r[1];
      win  = (m_since >= BLANK_CYC) && !PWM_synch;
      anyp = m_pl || m_pr;
      case (m_mode)
         0: if (PWM_synch) begin
               if (anyp) begin
                  m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
                  if (m_cnt == FAULT_CNT) begin
                     m_mode = 1;
                     m_fl = m_fl || m_pl;
                     m_fr = m_fr || m_pr;
                  end
               end else begin
                  m_cnt = 0;
               end
            end
         1: if (clr_fault) begin
               m_mode = 2; m_cnt = 0; m_rec = 0;
            end
         default: if (sl || sr) begin
               m_mode = 1;
            end else if (PWM_synch) begin
               m_rec++;
               if (m_rec == RECOV_CNT) begin
                  m_mode = 0; m_fl = 0; m_fr = 0;
               end
            end
      endcase
      if (PWM_synch) begin
         m_pl = 0; m_pr = 0;
      end else begin
         if (win && sl) m_pl = 1;
         if (win && sr) m_pr = 1;
      end
      m_since = PWM_synch ? 0 : ((m_since > 100000) ? m_since : m_since + 1);
      m_l[1] = m_l[0]; m_l[0] = OVR_I_lft;
      m_r[1] = m_r[0]; m_r[0] = OVR_I_rght;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("cyc_shtdwn", int'(OVR_I_shtdwn), int'(m_mode != 0));
      check("cyc_ovr_cnt", int'(ovr_cnt), m_cnt);
      check("cyc_fault_lft", int'(fault_lft), int'(m_fl && DIAG));
      check("cyc_fault_rght", int'(fault_rght), int'(m_fr && DIAG));
      if (watch && !OVR_I_shtdwn) sh_low = 1;
   endtask

   // One PWM period: pulse at k=0, over-current on [on,off) for selected sides
   task automatic run_period(input int plen, input int side, input int on,
                             input int off, input int clr_at);
      for (int k = 0; k < plen; k++) begin
         PWM_synch  = (k == 0);
         OVR_I_lft  = ((side & 1) != 0) && (k >= on) && (k < off);
         OVR_I_rght = ((side & 2) != 0) && (k >= on) && (k < off);
         clr_fault  = (k == clr_at);
         tick();
      end
      PWM_synch = 0; clr_fault = 0; OVR_I_lft = 0; OVR_I_rght = 0;
   endtask

   task automatic run_n(input int n, input int plen, input int side,
                        input int on, input int off);
      for (int p = 0; p < n; p++) run_period(plen, side, on, off, -1);
   endtask

   typedef struct {
      int         nper;
      int         plen;
      int         side;
      int         on;
      int         off;
      int         clr_at;
      logic [3:0] cnt;
      logic       sh;
      logic       fl;
      logic       fr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{20, 2048, 1,   5,  31, -1, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{ 7,  256, 2, 100, 201, -1, 4'd6, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{ 1,  256, 0,   0,   0, -1, 4'd7, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{ 1,  256, 0,   0,   0, 10, 4'd0, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{ 3,  256, 0,   0,   0, -1, 4'd0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{ 1,  256, 0,   0,   0, -1, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{ 6,  256, 1, 100, 201, -1, 4'd5, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{ 1,  256, 0,   0,   0, -1, 4'd6, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{ 6,  256, 1, 100, 201, -1, 4'd5, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{ 1,  256, 0,   0,   0, -1, 4'd6, 1'b0, 1'b0, 1'b0};

      watch = 0; sh_low = 0;
      rst_n = 0; OVR_I_lft = 0; OVR_I_rght = 0; PWM_synch = 0; clr_fault = 0;
      model_reset();
      #3;
      check("rst_shtdwn", int'(OVR_I_shtdwn), 0);
      check("rst_ovr_cnt", int'(ovr_cnt), 0);
      check("rst_fault_lft", int'(fault_lft), 0);
      check("rst_fault_rght", int'(fault_rght), 0);
      @(posedge clk); #1;
      rst_n = 1;

      // Directed period table
      for (int i = 0; i < 10; i++) begin
         for (int p = 0; p < vecs[i].nper; p++)
            run_period(vecs[i].plen, vecs[i].side, vecs[i].on, vecs[i].off,
                       (p == 0) ? vecs[i].clr_at : -1);
         check($sformatf("vec%0d_ovr_cnt", i), int'(ovr_cnt), int'(vecs[i].cnt));
         check($sformatf("vec%0d_shtdwn", i), int'(OVR_I_shtdwn), int'(vecs[i].sh));
         check($sformatf("vec%0d_fault_lft", i), int'(fault_lft), int'(vecs[i].fl && DIAG));
         check($sformatf("vec%0d_fault_rght", i), int'(fault_rght), int'(vecs[i].fr && DIAG));
      end

      // RECOVER -> FAULT: shutdown must stay high throughout
      run_n(7, 256, 2, 100, 201);
      run_period(256, 0, 0, 0, 10);
      check("recov_entry_cnt", int'(ovr_cnt), 0);
      run_n(2, 256, 0, 0, 0);
      watch = 1; sh_low = 0;
      for (int k = 0; k < 14; k++) begin
         PWM_synch = (k == 0);
         OVR_I_lft = (k >= 10);
         tick();
      end
      check("refault_by_3clk", int'(OVR_I_shtdwn), 1);
      for (int k = 14; k < 256; k++) begin
         PWM_synch = 0;
         OVR_I_lft = (k < 31);
         tick();
      end
      OVR_I_lft = 0;
      watch = 0;
      check("recov_sh_never_low", int'(sh_low), 0);

      // clr_fault together with a live over-current: RECOVER then FAULT again
      run_period(64, 1, 0, 64, 20);
      check("clr_with_ovr_sh", int'(OVR_I_shtdwn), 1);
      check("clr_with_ovr_cnt", int'(ovr_cnt), 0);
      run_period(256, 0, 0, 0, 10);
      run_n(4, 256, 0, 0, 0);
      check("recover_done_sh", int'(OVR_I_shtdwn), 0);

      // Trip, then asynchronous reset from FAULT
      run_n(7, 256, 2, 100, 201);
      run_period(8, 0, 0, 0, -1);
      check("trip2_sh", int'(OVR_I_shtdwn), 1);
      rst_n = 0;
      model_reset();
      #2;
      check("async_rst_sh", int'(OVR_I_shtdwn), 0);
      check("async_rst_cnt", int'(ovr_cnt), 0);
      check("async_rst_fl", int'(fault_lft), 0);
      check("async_rst_fr", int'(fault_rght), 0);
      @(posedge clk); #1;
      rst_n = 1;
      run_period(256, 0, 0, 0, -1);
      run_period(16, 0, 0, 0, -1);
      check("post_rst_sh", int'(OVR_I_shtdwn), 0);

      // Randomized periods against the model
      for (int p = 0; p < 60; p++) begin
         int plen, side, on, off, clr_at;
         plen   = $urandom_range(300, 30);
         side   = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(3, 1);
         on     = $urandom_range(plen - 1, 0);
         off    = $urandom_range(plen, on);
         clr_at = ($urandom_range(3, 0) == 0) ? $urandom_range(plen - 1, 0) : -1;
         run_period(plen, side, on, off, clr_at);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
